// File: rtl/reg_bank_8088_pkg.sv
// reg_bank_8088_pkg: opcodes, FSM states and bank geometry shared by the register bank
package reg_bank_8088_pkg;
  localparam int NREG = 16;
  localparam int W = 16;
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_WRW  = 3'd1;
  localparam logic [2:0] OP_WRL  = 3'd2;
  localparam logic [2:0] OP_WRH  = 3'd3;
  localparam logic [2:0] OP_XCHG = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  typedef enum logic {IDLE, XCHG2} state_t;
endpackage

// File: rtl/reg_bank_8088_alu.sv
// reg_bank_8088_alu: next-word generator feeding the single write port
module reg_bank_8088_alu
  import reg_bank_8088_pkg::*;
(
  input  logic [2:0]   op,
  input  logic [W-1:0] cur,
  input  logic [W-1:0] src_val,
  input  logic [W-1:0] din,
  output logic         we,
  output logic [W-1:0] nxt
);
  always_comb begin
    we  = op != OP_NOP && op != 3'd7;
    nxt = op == OP_WRW  ? din :
          op == OP_WRL  ? {cur[15:8], din[7:0]} :
          op == OP_WRH  ? {din[7:0], cur[7:0]} :
          op == OP_XCHG ? src_val :
          op == OP_INC  ? cur + 16'd1 :
          op == OP_DEC  ? cur - 16'd1 : cur;
  end
endmodule

// File: rtl/reg_bank_8088.sv
// reg_bank_8088: 16x16 register bank with byte writes, inc/dec and two-cycle exchange
module reg_bank_8088
  import reg_bank_8088_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op,
  input  logic [3:0]  dst,
  input  logic [3:0]  src,
  input  logic [15:0] din,
  output logic        done,
  output logic [15:0] r0,
  output logic [15:0] r1,
  output logic [15:0] r2,
  output logic [15:0] r3,
  output logic [15:0] r4,
  output logic [15:0] r5,
  output logic [15:0] r6,
  output logic [15:0] r7,
  output logic [15:0] r8,
  output logic [15:0] r9,
  output logic [15:0] r10,
  output logic [15:0] r11,
  output logic [15:0] r12,
  output logic [15:0] r13,
  output logic [15:0] r14,
  output logic [15:0] r15
);
  logic [W-1:0] r [NREG];
  logic [W-1:0] tmp, alu_out, wdata;
  logic [3:0] src_q, waddr;
  logic alu_we, accept, we;
  state_t state, state_nx;
  assign op_ready = state == IDLE && !rst;
  assign accept = op_valid && op_ready;
  reg_bank_8088_alu u_alu (
    .op(op),
    .cur(r[dst]),
    .src_val(r[src]),
    .din(din),
    .we(alu_we),
    .nxt(alu_out)
  );
  always_comb begin
    state_nx = accept && op == OP_XCHG ? XCHG2 : IDLE;
    we = state == XCHG2 || (accept && alu_we);
    waddr = state == XCHG2 ? src_q : dst;
    wdata = state == XCHG2 ? tmp : alu_out;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tmp <= '0;
      src_q <= '0;
      done <= 1'b0;
      for (int i = 0; i < NREG; i++) r[i] <= RESET_VAL;
    end else begin
      state <= state_nx;
      done <= state == XCHG2 || (accept && op != OP_XCHG);
      if (accept && op == OP_XCHG) begin
        tmp <= r[dst];
        src_q <= src;
      end
      if (we) r[waddr] <= wdata;
    end
  end
  assign r0  = r[0];
  assign r1  = r[1];
  assign r2  = r[2];
  assign r3  = r[3];
  assign r4  = r[4];
  assign r5  = r[5];
  assign r6  = r[6];
  assign r7  = r[7];
  assign r8  = r[8];
  assign r9  = r[9];
  assign r10 = r[10];
  assign r11 = r[11];
  assign r12 = r[12];
  assign r13 = r[13];
  assign r14 = r[14];
  assign r15 = r[15];
endmodule

// File: tb/tb_reg_bank_8088.sv
// tb_reg_bank_8088: directed and random checks of the register bank against a behavioural model
module tb_reg_bank_8088;
  logic clk = 1'b0;
  logic rst, op_valid, op_ready, done;
  logic [2:0] op;
  logic [3:0] dst, src;
  logic [15:0] din;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15;
  logic [15:0] rv [16];
  logic [15:0] m [16];
  logic m_busy, m_done;
  logic [3:0] m_xs;
  logic [15:0] m_xt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_bank_8088 dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .dst(dst), .src(src), .din(din), .done(done),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15)
  );

  assign rv = '{r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge: what the bank must hold after it, from the rules alone
  task automatic model_edge();
    logic [15:0] t;
    m_done = 1'b0;
    if (rst) begin
      for (int i = 0; i < 16; i++) m[i] = 16'h0000;
      m_busy = 1'b0;
    end else if (m_busy) begin
      m[m_xs] = m_xt;
      m_busy = 1'b0;
      m_done = 1'b1;
    end else if (op_valid) begin
      m_done = 1'b1;
      case (op)
        3'd1: m[dst] = din;
        3'd2: m[dst][7:0] = din[7:0];
        3'd3: m[dst][15:8] = din[7:0];
        3'd4: begin
          t = m[dst];
          m[dst] = m[src];
          m_xs = src;
          m_xt = t;
          m_busy = 1'b1;
          m_done = 1'b0;
        end
        3'd5: m[dst] = m[dst] + 16'd1;
        3'd6: m[dst] = m[dst] - 16'd1;
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 16; i++) chk($sformatf("r%0d", i), rv[i], m[i]);
    chk("op_ready", {15'd0, op_ready}, {15'd0, !m_busy && !rst});
    chk("done", {15'd0, done}, {15'd0, m_done});
  endtask

  task automatic step(input logic v, input logic [2:0] o, input logic [3:0] d,
                      input logic [3:0] s, input logic [15:0] di, input logic rr);
    op_valid = v; op = o; dst = d; src = s; din = di; rst = rr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    m_busy = 1'b0; m_done = 1'b0; m_xs = '0; m_xt = '0;
    for (int i = 0; i < 16; i++) m[i] = 16'h0000;
    @(negedge clk);
    step(1'b0, 3'd0, 4'd0, 4'd0, 16'h0, 1'b1);
    step(1'b0, 3'd0, 4'd0, 4'd0, 16'h0, 1'b0);
    chk("reset r9", r9, 16'h0000);
    chk("reset ready", {15'd0, op_ready}, 16'd1);
    chk("reset done", {15'd0, done}, 16'd0);
    step(1'b1, 3'd1, 4'd3, 4'd0, 16'h1234, 1'b0);
    chk("wrw r3", r3, 16'h1234);
    chk("wrw done", {15'd0, done}, 16'd1);
    step(1'b1, 3'd2, 4'd3, 4'd0, 16'h00AB, 1'b0);
    chk("wrl r3", r3, 16'h12AB);
    chk("wrl done", {15'd0, done}, 16'd1);
    step(1'b1, 3'd3, 4'd3, 4'd0, 16'h00CD, 1'b0);
    chk("wrh r3", r3, 16'hCDAB);
    chk("wrh done", {15'd0, done}, 16'd1);
    step(1'b1, 3'd1, 4'd7, 4'd0, 16'hFFFF, 1'b0);
    step(1'b1, 3'd5, 4'd7, 4'd0, 16'h0000, 1'b0);
    chk("inc wrap", r7, 16'h0000);
    step(1'b1, 3'd6, 4'd7, 4'd0, 16'h0000, 1'b0);
    chk("dec wrap", r7, 16'hFFFF);
    step(1'b1, 3'd7, 4'd7, 4'd0, 16'h1111, 1'b0);
    chk("reserved r7", r7, 16'hFFFF);
    chk("reserved done", {15'd0, done}, 16'd1);
    step(1'b1, 3'd1, 4'd1, 4'd0, 16'hAAAA, 1'b0);
    step(1'b1, 3'd1, 4'd2, 4'd0, 16'h5555, 1'b0);
    step(1'b1, 3'd4, 4'd1, 4'd2, 16'h0000, 1'b0);
    chk("xchg e1 r1", r1, 16'h5555);
    chk("xchg e1 ready", {15'd0, op_ready}, 16'd0);
    chk("xchg e1 done", {15'd0, done}, 16'd0);
    step(1'b1, 3'd1, 4'd1, 4'd0, 16'h0BAD, 1'b0);
    chk("xchg e2 r2", r2, 16'hAAAA);
    chk("xchg held r1", r1, 16'h5555);
    chk("xchg e2 done", {15'd0, done}, 16'd1);
    step(1'b1, 3'd1, 4'd6, 4'd0, 16'h1357, 1'b0);
    step(1'b1, 3'd4, 4'd6, 4'd6, 16'h0000, 1'b0);
    step(1'b0, 3'd0, 4'd0, 4'd0, 16'h0000, 1'b0);
    chk("xchg self r6", r6, 16'h1357);
    chk("xchg self done", {15'd0, done}, 16'd1);
    step(1'b1, 3'd1, 4'd4, 4'd0, 16'h4444, 1'b0);
    step(1'b1, 3'd1, 4'd5, 4'd0, 16'h5A5A, 1'b0);
    step(1'b1, 3'd4, 4'd4, 4'd5, 16'h0000, 1'b0);
    chk("abort e1 r4", r4, 16'h5A5A);
    step(1'b1, 3'd1, 4'd4, 4'd0, 16'hFFFF, 1'b1);
    chk("abort r4", r4, 16'h0000);
    chk("abort r5", r5, 16'h0000);
    chk("abort done", {15'd0, done}, 16'd0);
    step(1'b0, 3'd0, 4'd0, 4'd0, 16'h0000, 1'b0);
    chk("abort ready", {15'd0, op_ready}, 16'd1);
    chk("abort no done", {15'd0, done}, 16'd0);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 49) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_bank_8088.md
REG_BANK_8088 -- requirements
Module: reg_bank_8088

Interface
REQ-001 SHALL have parameter: RESET_VAL, 16'h0000, value loaded into every register on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: op_valid  input  1  operation request present.
REQ-005 SHALL have port: op_ready  output  1  block can accept an operation this cycle.
REQ-006 SHALL have port: op  input  3  opcode: 000 NOP, 001 WRW, 010 WRL, 011 WRH, 100 XCHG, 101 INC, 110 DEC, 111 reserved (treated as NOP).
REQ-007 SHALL have port: dst  input  4  destination register index.
REQ-008 SHALL have port: src  input  4  source register index (XCHG only).
REQ-009 SHALL have port: din  input  16  write data (WRW full word; WRL/WRH use din[7:0]).
REQ-010 SHALL have port: done  output  1  one-cycle pulse when an accepted operation has fully committed.
REQ-011 SHALL have ports: r0..r15  output  16 each  registered contents of registers 0..15, wired directly to the downstream 16:1 read multiplexer inputs A0..A15.

Function
REQ-012 SHALL accept an operation at a rising edge where op_valid=1 and op_ready=1; op, dst, src, din sampled at that edge only.
REQ-013 SHALL drive op_ready=1 exactly when FSM is in IDLE and rst=0.
REQ-014 SHALL implement FSM states IDLE and XCHG2; IDLE->XCHG2 on accepted XCHG; XCHG2->IDLE unconditionally next edge; all other accepted ops stay IDLE.
REQ-015 SHALL perform at most one register write per edge (single write port).
REQ-016 WRW SHALL set r[dst]<=din at accept edge.
REQ-017 WRL SHALL set r[dst][7:0]<=din[7:0], r[dst][15:8] unchanged.
REQ-018 WRH SHALL set r[dst][15:8]<=din[7:0], r[dst][7:0] unchanged.
REQ-019 INC/DEC SHALL set r[dst]<=r[dst]±1 modulo 2^16 (16'hFFFF+1=16'h0000; 16'h0000-1=16'hFFFF).
REQ-020 XCHG accept edge SHALL set r[dst]<=r[src] and capture old r[dst] into internal tmp; XCHG2 edge SHALL set r[src]<=tmp.
REQ-021 XCHG with dst==src SHALL take 2 cycles and leave the register unchanged.
REQ-022 NOP/reserved accepted SHALL change no register but still pulse done.
REQ-023 done SHALL be 1 in the cycle after the committing edge (accept edge for single-cycle ops, XCHG2 edge for XCHG), else 0.
REQ-024 Throughput: single-cycle ops back-to-back every cycle; XCHG occupies 2 cycles, op_ready=0 during XCHG2.
REQ-025 op_valid while op_ready=0 SHALL be ignored (requester must hold it).
REQ-026 r0..r15 SHALL reflect updates the cycle after the writing edge; no combinational path from din to r outputs.

Reset
REQ-027 rst=1 at an edge SHALL set r0..r15=RESET_VAL, tmp=0, FSM=IDLE, done=0; op_ready=0 while rst=1.
REQ-028 rst during XCHG2 SHALL abort the exchange: second write not performed, no done pulse.
REQ-029 rst SHALL take priority over any simultaneous accepted operation.

Structure
REQ-030 Shared package SHALL hold opcode constants (OP_NOP..OP_DEC), FSM state encoding, register count 16 and width 16.
REQ-031 One sub-module natural: reg_bank_8088_alu (combinational next-word generator: byte merge, ±1, pass-through) feeding the single write port.

Verification
REQ-032 Reset: rst 1 cycle -> all r0..r15=16'h0000, op_ready=1, done=0 next cycle.
REQ-033 Byte lanes: WRW r3=16'h1234, WRL r3 din=16'h00AB, WRH r3 din=16'h00CD -> r3=16'h1234, 16'h12AB, 16'hCDAB, done pulse each cycle.
REQ-034 Wrap: WRW r7=16'hFFFF, INC r7 -> 16'h0000; DEC r7 -> 16'hFFFF.
REQ-035 Exchange: r1=16'hAAAA, r2=16'h5555, XCHG dst=1 src=2 -> after edge1 r1=16'h5555, op_ready=0; after edge2 r2=16'hAAAA, done=1; op_valid held during XCHG2 ignored.
REQ-036 Abort: XCHG dst=4 src=5 then rst asserted during XCHG2 -> all registers 16'h0000, no done pulse, op_ready=1 after rst released.
